// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one result bit per clock, LSB first.
// Latency: WIDTH cycles from the accepting start edge to the done pulse.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
//
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   start            - begin an operation (sampled only while idle)
//   mode             - 0: a - b - cin, 1: a + b + cin
//   a, b, cin        - operands and borrow/carry-in, captured at the accepting edge
//   s, cout, ovf     - registered result, final borrow/carry, signed overflow
//   busy             - operation in progress
//   done             - one-cycle pulse: s/cout/ovf just updated
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             cy;
  logic             op_mode;

  logic accept;
  logic last;
  logic bit_a;
  logic bit_b;
  logic res_bit;
  logic cy_nxt;
  logic ovf_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        last = (cnt == LAST);
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-bit full adder / full subtractor on the current LSBs.
  assign bit_a   = a_sh[0];
  assign bit_b   = b_sh[0];
  assign res_bit = bit_a ^ bit_b ^ cy;
  assign cy_nxt  = op_mode ? ((bit_a & bit_b) | (cy & (bit_a ^ bit_b)))
                           : ((~bit_a & bit_b) | (cy & ~(bit_a ^ bit_b)));

  // On the last bit, a_sh[0]/b_sh[0] are the original operand MSBs and
  // res_bit is the result MSB.
  assign ovf_nxt = op_mode ? ((bit_a == bit_b) && (res_bit != bit_a))
                           : ((bit_a != bit_b) && (res_bit != bit_a));

  assign busy = (state == RUN);

  // Datapath. Result bits are shifted into the top of a_sh as operand bits
  // leave from the bottom, so a_sh holds the full result after WIDTH shifts;
  // s itself only changes on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cy      <= 1'b0;
      op_mode <= 1'b0;
      cnt     <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        cy      <= cin;
        op_mode <= mode;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sh <= {res_bit, a_sh[WIDTH-1:1]};
        b_sh <= b_sh >> 1;
        cy   <= cy_nxt;
        cnt  <= cnt + 1'b1;
        if (last) begin
          s    <= {res_bit, a_sh[WIDTH-1:1]};
          cout <= cy_nxt;
          ovf  <= ovf_nxt;
          done <= 1'b1;
          cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed operations with literal expectations,
// plus an operation-level reference model compared on every cycle.
module tb_serial_addsub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: plain integer add/subtract, ovf from the MSB rule.
  function automatic void model_result(input logic md, input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, output logic [W-1:0] r,
                                       output logic co, output logic ov);
    int t;
    if (md) t = int'(x) + int'(y) + int'(ci);
    else    t = int'(x) - int'(y) - int'(ci);
    r  = t[W-1:0];
    co = md ? (t >= (1 << W)) : (t < 0);
    ov = md ? ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1]))
            : ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]));
  endfunction

  // Operation-level model: an accepted op completes WIDTH edges later.
  int           m_rem  = 0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_s    = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         op_mode, op_cin;
  logic [W-1:0] op_a, op_b;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
      m_s = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          model_result(op_mode, op_a, op_b, op_cin, m_s, m_cout, m_ovf);
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        op_mode = mode; op_a = a; op_b = b; op_cin = cin;
        m_rem  = W;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_s",    s,    m_s);
      chk("cyc_cout", cout, m_cout);
      chk("cyc_ovf",  ovf,  m_ovf);
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (done !== 1'b1 && lat < 40);
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_done: no done within %0d cycles", lat);
    end
  endtask

  task automatic run_op(input logic md, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    @(negedge clk);
    mode = md; a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: the captured operation must be unaffected.
    start = 1'b0; a = ~x; b = ~y; cin = ~ci; mode = ~md;
    wait_done(lat);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int           lat;
    int           n;
    logic [W-1:0] r;
    logic         co, ov;

    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Pin the reference model against hand-computed values.
    model_result(1'b0, 8'h05, 8'h03, 1'b0, r, co, ov);
    chk("model_sub_s", r, 8'h02);
    model_result(1'b0, 8'h80, 8'h01, 1'b0, r, co, ov);
    chk("model_sub_ovf", ov, 1'b1);
    model_result(1'b1, 8'hFF, 8'h01, 1'b1, r, co, ov);
    chk("model_add_s", r, 8'h01);
    chk("model_add_cout", co, 1'b1);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_s", s, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "sub_5_3");
    run_op(1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "sub_0_1");
    run_op(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_0_0_bin");
    run_op(1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "sub_ovf");
    run_op(1'b1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "add_wrap");
    run_op(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf");

    // Start pulsed in busy cycle 3 is ignored.
    @(negedge clk);
    mode = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h77; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ignore_s", s, 8'h30);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("ignore_extra_done", n, 0);

    // Start held high: second op accepted in the done cycle, no gap.
    @(negedge clk);
    mode = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(lat);
    chk("b2b_first_latency", lat, W);
    chk("b2b_first_s", s, 8'h03);
    mode = 1'b0; a = 8'h40; b = 8'h41; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    chk("b2b_second_busy", busy, 1'b1);
    wait_done(lat);
    chk("b2b_second_latency", lat, W);
    chk("b2b_second_s", s, 8'hFF);
    chk("b2b_second_cout", cout, 1'b1);

    // Reset in busy cycle 4 aborts the op without done.
    @(negedge clk);
    mode = 1'b1; a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_s", s, 8'h00);
    chk("abort_cout", cout, 1'b0);
    chk("abort_done", done, 1'b0);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);
    run_op(1'b1, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, "after_abort");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port mode, input, 1, 0 = subtract (a - b - cin), 1 = add (a + b + cin).
REQ-006 The block SHALL have port a, input, WIDTH, minuend/augend.
REQ-007 The block SHALL have port b, input, WIDTH, subtrahend/addend.
REQ-008 The block SHALL have port cin, input, 1, borrow-in (mode 0) or carry-in (mode 1).
REQ-009 The block SHALL have port s, output, WIDTH, registered result.
REQ-010 The block SHALL have port cout, output, 1, final borrow-out (mode 0) or carry-out (mode 1).
REQ-011 The block SHALL have port ovf, output, 1, two's-complement signed overflow of the result.
REQ-012 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse marking result valid.

Function
REQ-014 The block SHALL implement states IDLE and RUN; IDLE -> RUN on start=1 at an edge while in IDLE; RUN -> IDLE after WIDTH bit cycles.
REQ-015 The block SHALL capture a, b, cin, mode at the accepting edge (E0); later input changes SHALL NOT affect the operation.
REQ-016 The block SHALL assert busy from the cycle after E0 through the cycle ending at edge E(WIDTH).
REQ-017 The block SHALL process one bit per edge, LSB first: at edge Ei (i=1..WIDTH) bit i-1 is resolved with the one-bit full-subtractor (mode 0) or full-adder (mode 1) equation, using the registered borrow/carry from bit i-2 (cin for bit 0).
REQ-018 The block SHALL update s, cout, ovf only at edge E(WIDTH), and SHALL hold them unchanged until the next completion or reset; partial results SHALL NOT appear on s.
REQ-019 The block SHALL pulse done high for exactly the one cycle following E(WIDTH); start-to-done latency SHALL be WIDTH cycles.
REQ-020 The block SHALL compute ovf in mode 0 as (a_msb != b_msb) and (s_msb != a_msb); in mode 1 as (a_msb == b_msb) and (s_msb != a_msb).
REQ-021 The block SHALL wrap results modulo 2^WIDTH; cout SHALL carry the out-of-range bit (borrow=1 when a < b + cin unsigned; carry=1 when a + b + cin >= 2^WIDTH).
REQ-022 The block SHALL ignore start while busy=1; no queuing, the in-flight operation SHALL be unaffected.
REQ-023 The block SHALL accept a new start in the same cycle done=1 (state already IDLE), giving back-to-back operations with no idle gap.

Reset
REQ-024 The block SHALL, on rst=1 at any edge, enter IDLE and set s=0, cout=0, ovf=0, busy=0, done=0, internal bit counter and borrow/carry register to 0.
REQ-025 The block SHALL give rst priority over start in the same cycle; an operation aborted by reset SHALL NOT produce done.

Verification
REQ-026 The bench SHALL check WIDTH=8, mode=0, a=0x05, b=0x03, cin=0 -> s=0x02, cout=0, ovf=0, done exactly 8 cycles after start edge.
REQ-027 The bench SHALL check mode=0, a=0x00, b=0x01, cin=0 -> s=0xFF, cout=1, ovf=0; and a=0x00, b=0x00, cin=1 -> s=0xFF, cout=1.
REQ-028 The bench SHALL check mode=0, a=0x80, b=0x01, cin=0 -> s=0x7F, cout=0, ovf=1.
REQ-029 The bench SHALL check mode=1, a=0xFF, b=0x01, cin=1 -> s=0x01, cout=1, ovf=0; and a=0x7F, b=0x01, cin=0 -> s=0x80, ovf=1.
REQ-030 The bench SHALL check start pulsed at cycle 3 of a busy operation is ignored (single done, original result), and start held with done gives back-to-back results.
REQ-031 The bench SHALL check rst=1 at cycle 4 of an operation -> busy=0, s=0, no done pulse; next start completes normally.
